// File: rtl/predictor_update_scheduler_pkg.sv
// Shared constants and types for the branch-predictor update scheduler.
// Table geometry, FIFO depth, FSM encoding and the queued-update record.
package predictor_update_scheduler_pkg;

    localparam int ADDR_W          = 32;
    localparam int PREDICTOR_SIZE  = 512;
    localparam int IDX_W           = 9;
    localparam int FIFO_DEPTH      = 4;
    localparam logic [1:0] INIT_VALUE = 2'b01;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // One pending training update: table index plus branch direction.
    typedef struct packed {
        idx_t index;
        logic taken;
    } update_t;

endpackage

// File: rtl/predictor_update_fifo.sv
// Small power-of-two FIFO holding pending predictor training updates.
// Head is read combinationally so a pop can issue in the same cycle.
module predictor_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full      = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign head_data = mem[rd_ptr_reg];

    // Full is decided from registered occupancy only, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/predictor_update_scheduler.sv
// Serialises table-init walks and committed-branch training updates onto
// the predictor's single counter-table write port.
module predictor_update_scheduler
    import predictor_update_scheduler_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             enable_from_reorderbuffer,
    input  logic [ADDR_W-1:0] inst_addr_from_reorderbuffer,
    input  logic             jump_result_from_reorderbuffer,
    output logic             full_to_reorderbuffer,
    input  logic             clear_req,
    output logic             busy_out,
    output logic             wr_en_to_predictor,
    output logic [IDX_W-1:0] wr_index_to_predictor,
    output logic             wr_init_to_predictor,
    output logic             wr_taken_to_predictor
);

    state_t state_reg, state_next;
    idx_t   walk_reg, walk_next;

    logic   wr_en_reg, wr_en_next;
    idx_t   wr_index_reg, wr_index_next;
    logic   wr_init_reg, wr_init_next;
    logic   wr_taken_reg, wr_taken_next;
    logic   busy_reg, busy_next;

    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_flush;
    logic    fifo_full;
    logic    fifo_empty;
    update_t fifo_in;
    update_t fifo_head;

    // Only the low PC bits index the table.
    logic addr_unused;
    assign addr_unused = ^inst_addr_from_reorderbuffer[ADDR_W-1:IDX_W];

    assign fifo_in.index = inst_addr_from_reorderbuffer[IDX_W-1:0];
    assign fifo_in.taken = jump_result_from_reorderbuffer;

    predictor_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(update_t))
    ) u_fifo (
        .clk       (clk_in),
        .srst      (rst_in),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data (fifo_in),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_CLEAR;
            walk_reg     <= '0;
            wr_en_reg    <= FALSE;
            wr_index_reg <= '0;
            wr_init_reg  <= FALSE;
            wr_taken_reg <= FALSE;
            busy_reg     <= FALSE;
        end else begin
            state_reg    <= state_next;
            walk_reg     <= walk_next;
            wr_en_reg    <= wr_en_next;
            wr_index_reg <= wr_index_next;
            wr_init_reg  <= wr_init_next;
            wr_taken_reg <= wr_taken_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        walk_next     = walk_reg;
        wr_en_next    = FALSE;
        wr_index_next = wr_index_reg;
        wr_init_next  = wr_init_reg;
        wr_taken_next = wr_taken_reg;
        busy_next     = busy_reg;
        fifo_push     = FALSE;
        fifo_pop      = FALSE;
        fifo_flush    = FALSE;

        if (rdy_in) begin
            fifo_push = enable_from_reorderbuffer;
            // Busy tracks the state that produced the write being presented.
            busy_next = (state_reg == ST_CLEAR);
            unique case (state_reg)
                ST_CLEAR: begin
                    wr_en_next    = TRUE;
                    wr_init_next  = TRUE;
                    wr_taken_next = FALSE;
                    if (clear_req) begin
                        wr_index_next = '0;
                        walk_next     = idx_t'(1);
                    end else begin
                        wr_index_next = walk_reg;
                        walk_next     = walk_reg + 1'b1;
                        if (walk_reg == idx_t'(PREDICTOR_SIZE - 1)) begin
                            state_next = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!fifo_empty) begin
                        fifo_pop      = TRUE;
                        wr_en_next    = TRUE;
                        wr_init_next  = FALSE;
                        wr_index_next = fifo_head.index;
                        wr_taken_next = fifo_head.taken;
                    end
                    // Queued history is stale once the table is wiped.
                    if (clear_req) begin
                        state_next = ST_CLEAR;
                        walk_next  = '0;
                        fifo_flush = TRUE;
                    end
                end
                default: state_next = ST_CLEAR;
            endcase
        end
    end

    assign full_to_reorderbuffer = fifo_full;
    assign busy_out              = busy_reg;
    assign wr_en_to_predictor    = wr_en_reg;
    assign wr_index_to_predictor = wr_index_reg;
    assign wr_init_to_predictor  = wr_init_reg;
    assign wr_taken_to_predictor = wr_taken_reg;

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// Randomised bench for predictor_update_scheduler with a queue-based
// reference model of the init walk and the commit-update buffer.
module tb_predictor_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        jtaken;
    logic        clr;
    logic        full;
    logic        busy;
    logic        wr_en;
    logic [8:0]  wr_index;
    logic        wr_init;
    logic        wr_taken;

    int total = 0;
    int bad   = 0;

    predictor_update_scheduler dut (
        .clk_in                         (clk),
        .rst_in                         (rst),
        .rdy_in                         (rdy),
        .enable_from_reorderbuffer      (en),
        .inst_addr_from_reorderbuffer   (addr),
        .jump_result_from_reorderbuffer (jtaken),
        .full_to_reorderbuffer          (full),
        .clear_req                      (clr),
        .busy_out                       (busy),
        .wr_en_to_predictor             (wr_en),
        .wr_index_to_predictor          (wr_index),
        .wr_init_to_predictor           (wr_init),
        .wr_taken_to_predictor          (wr_taken)
    );

    always #5 clk = ~clk;

    // Reference model: pending updates as {index, taken}, plus walk position.
    bit [9:0] q[$];
    bit       walking = 1'b1;
    int       pos     = 0;
    bit       e_en, e_init, e_tk, e_busy, e_full;
    bit [8:0] e_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rd, input bit e, input logic [31:0] a,
                        input bit t, input bit c);
        bit       acc;
        bit [9:0] ent;
        rst = r; rdy = rd; en = e; addr = a; jtaken = t; clr = c;
        if (r) begin
            q.delete();
            walking = 1'b1; pos = 0;
            e_en = 0; e_idx = '0; e_init = 0; e_tk = 0; e_busy = 0;
        end else if (!rd) begin
            e_en = 0;
        end else begin
            acc    = e && (q.size() < 4);
            e_busy = walking;
            if (walking) begin
                e_en = 1; e_init = 1; e_tk = 0;
                if (c) begin
                    e_idx = '0; pos = 1;
                end else begin
                    e_idx = pos[8:0];
                    pos++;
                    if (pos == 512) begin
                        walking = 1'b0; pos = 0;
                    end
                end
            end else begin
                if (q.size() > 0) begin
                    ent = q.pop_front();
                    e_en = 1; e_init = 0; e_idx = ent[9:1]; e_tk = ent[0];
                end else begin
                    e_en = 0;
                end
                if (c) begin
                    walking = 1'b1; pos = 0; q.delete(); acc = 0;
                end
            end
            if (acc) q.push_back({a[8:0], t});
        end
        e_full = (q.size() == 4);
        @(negedge clk);
        check_eq("wr_en", wr_en, e_en);
        check_eq("wr_index", wr_index, e_idx);
        check_eq("wr_init", wr_init, e_init);
        check_eq("wr_taken", wr_taken, e_tk);
        check_eq("busy", busy, e_busy);
        check_eq("full", full, e_full);
        if (e_en && !e_init)
            $display("commit update: index=%03h taken=%0b", e_idx, e_tk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 32'h0, 0, 0);
    endtask

    initial begin
        int busy_cnt;
        rst = 1; rdy = 1; en = 0; addr = '0; jtaken = 0; clr = 0;

        // Reset then full init walk; count busy cycles.
        step(1, 1, 0, 32'h0, 0, 0);
        step(1, 1, 0, 32'h0, 0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 520; i++) begin
            step(0, 1, 0, 32'h0, 0, 0);
            if (busy) busy_cnt++;
        end
        check_eq("busy_cycles", busy_cnt, 512);

        // Single commit after init.
        step(0, 1, 1, 32'h0000_1004, 1, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        check_eq("t2_index", wr_index, 32'h004);
        check_eq("t2_taken", wr_taken, 1);
        idle(3);

        // Five pushes during the walk: fifth dropped, four drain in order.
        step(1, 1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, $urandom, 1'($urandom), 0);
        check_eq("t3_full", full, 1);
        idle(515);

        // Steady push stream in DRAIN.
        for (int i = 0; i < 20; i++) step(0, 1, 1, $urandom, 1'($urandom), 0);
        idle(3);

        // Clear with three entries queued on the first drain cycle.
        step(1, 1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, $urandom, 1'($urandom), 0);
        idle(509);
        step(0, 1, 0, 32'h0, 0, 1);
        step(0, 1, 0, 32'h0, 0, 0);
        check_eq("t5_restart_idx", wr_index, 0);
        check_eq("t5_busy", busy, 1);
        idle(10);

        // Stall mid-walk at index 100, then reset around index 300.
        step(1, 1, 0, 32'h0, 0, 0);
        idle(100);
        for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom, 1'($urandom), 1);
        step(0, 1, 0, 32'h0, 0, 0);
        check_eq("t6_resume_idx", wr_index, 100);
        idle(199);
        step(1, 1, 0, 32'h0, 0, 0);
        idle(50);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 999) == 0, $urandom_range(0, 9) != 0,
                 1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 199) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
